cache_line_sequencer: RTL
=========================

// Module: cache_line_sequencer
// PURPOSE
//  Miss/flush sequencer for the NRU tag manager and its cache data array. On a core miss it
//  writes back the dirty victim (if any), refills the line from the system bus and pulses
//  line_refill. It also runs the flush (write back all dirty lines) and invalidate-all
//  maintenance operations. It stalls the core while busy.
//  Sits between the core, the tag manager, the data array and the BIU bus master port.
// PARAMETERS
//  SEL_WIDTH   3   entry select width, matches the tag manager
//  ADDR_W      32  byte address width
//  DATA_W      32  bus/data word width
//  LINE_WORDS  8   words per line, power of 2 and >=2; OFF_W=$clog2(LINE_WORDS)
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          async active-low reset
//  core_req       in   1          core access valid (read|wthru|wback)
//  access_addr    in   ADDR_W     core address (refill line base = addr & ~(LINE_WORDS*4-1))
//  line_miss      in   1          from tag manager
//  replace_dirty  in   1          victim line dirty
//  victim_addr    in   ADDR_W     line base address of the victim/dirty-select entry
//  any_dirty      in   1          OR of all dirty bits
//  flush_req      in   1          level request: write back all dirty lines
//  inval_req      in   1          level request: invalidate all lines
//  core_stall     out  1          hold core access
//  force_sync     out  1          selects the dirty encoder in the tag manager
//  line_refill    out  1          1-cycle pulse: tag/valid update for entry_replace_sel
//  writeback_ok   out  1          1-cycle pulse: clear dirty of entry_replace_sel
//  valid_clear    out  1          1-cycle pulse: invalidate all
//  maint_done     out  1          1-cycle pulse: flush/inval finished
//  mem_off        out  OFF_W      data array word offset (entry = entry_replace_sel)
//  mem_we         out  1          data array write strobe
//  mem_wdata      out  DATA_W     = bus_rdata
//  mem_rdata      in   DATA_W     data array read, combinational in mem_off
//  bus_valid      out  1          beat request
//  bus_we         out  1          1=write beat, 0=read beat
//  bus_addr       out  ADDR_W     line base + (beat<<2)
//  bus_wdata      out  DATA_W     = mem_rdata
//  bus_ready      in   1          beat accept; read data valid same cycle
//  bus_rdata      in   DATA_W     read data
//  bus_err        out  1          1-cycle pulse on bus timeout (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE, beat=0, every output 0 except core_stall=0. Async assert, sync-free release.
//  A beat completes when bus_valid&bus_ready. bus_valid holds, with addr/data stable, until
//  ready. No combinational path from bus_ready to bus_valid.
//  States:
//   IDLE: core_req&line_miss -> replace_dirty ? WB : RF (miss wins over maint).
//         else flush_req -> any_dirty ? FWB (force_sync=1) : DONE; else inval_req -> INV.
//   WB:   write beats 0..LINE_WORDS-1 to victim_addr. Last beat -> WBOK.
//   WBOK: writeback_ok=1 for 1 cycle -> RF (miss) or FCHK (flush).
//   RF:   read beats to refill base; mem_we=1 on each completed beat. Last beat -> FILL.
//   FILL: line_refill=1 for 1 cycle -> IDLE. Tag manager re-evaluates the hit next cycle.
//   FWB:  like WB with force_sync=1. FCHK: any_dirty ? FWB : DONE.
//   INV:  valid_clear=1 for 1 cycle -> DONE. DONE: maint_done=1 -> IDLE.
//  core_stall = core_req&line_miss in IDLE, or state!=IDLE.
//  Beat counter is OFF_W bits and wraps to 0 after the last beat; mem_off = beat.
//  Minimum clean-miss latency: LINE_WORDS beats + 1 (FILL) + 1 (hit) cycles.
//  Refill base and victim_addr are sampled on leaving IDLE and held for the whole operation.
//  force_sync stays high through FWB/WBOK/FCHK so the victim select stays stable.
//  flush_req and inval_req both high in IDLE: flush first; inval is then taken from IDLE
//  if still asserted. Requesters drop req on maint_done.
//  Requests are not aborted. rst_n low mid-burst drops to IDLE immediately; the line stays
//  invalid/dirty as before.
// CONFIGURATION
//  `BUS_TIMEOUT_EN defined: 8-bit counter runs while bus_valid&!bus_ready and clears on each
//   beat. At 255: bus_err pulses, bus_valid drops, state -> IDLE with no line_refill and no
//   writeback_ok. core_stall is released.
//  Undefined: no counter, bus_err tied 0, waits forever.
// TESTING
//  Clean miss: line_miss=1, replace_dirty=0, addr 0x1234 -> 8 reads at 0x1220..0x123C,
//   mem_we x8, line_refill 1 cycle, stall drops.
//  Dirty miss: victim_addr 0x8000 -> 8 writes 0x8000..0x801C, then writeback_ok, then refill.
//   bus_we stays 0 after the WB phase.
//  Ready stalls: bus_ready low for 3 cycles on beat 5 -> addr/wdata held, no mem_we, count correct.
//  Flush with 2 dirty lines: force_sync high throughout, 2 WB bursts + 2 writeback_ok,
//   then maint_done. Flush with any_dirty=0 -> maint_done 2 cycles after request.
//  flush_req+inval_req together: flush completes, then valid_clear, two maint_done.
//   rst_n low at beat 3 -> all outputs 0 asynchronously.
//  `BUS_TIMEOUT_EN: hold bus_ready=0 -> bus_err at 255th waiting cycle, IDLE, no line_refill.

Source files
------------

// File: rtl/cache_line_sequencer.sv
// Miss/flush sequencer: victim write-back, line refill, flush-all and invalidate-all bursts.
// Optional bus watchdog is enabled by defining BUS_TIMEOUT_EN.
module cache_line_sequencer #(
    parameter int SEL_WIDTH  = 3,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8,
    localparam int OFF_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] access_addr,
    input  logic              line_miss,
    input  logic              replace_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic              any_dirty,
    input  logic              flush_req,
    input  logic              inval_req,
    output logic              core_stall,
    output logic              force_sync,
    output logic              line_refill,
    output logic              writeback_ok,
    output logic              valid_clear,
    output logic              maint_done,
    output logic [OFF_W-1:0]  mem_off,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err,
    output logic [3:0]        dbg_state_o
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_WB   = 4'd1;
    localparam logic [3:0] S_WBOK = 4'd2;
    localparam logic [3:0] S_RF   = 4'd3;
    localparam logic [3:0] S_FILL = 4'd4;
    localparam logic [3:0] S_FWB  = 4'd5;
    localparam logic [3:0] S_FCHK = 4'd6;
    localparam logic [3:0] S_INV  = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

    logic [3:0]        state_q, state_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] rf_base_q, rf_base_d;
    logic [ADDR_W-1:0] wb_base_q, wb_base_d;
    logic              flush_q, flush_d;
    logic              in_wb, in_rf, beat_done, timeout;

    assign in_wb     = (state_q == S_WB) || (state_q == S_FWB);
    assign in_rf     = (state_q == S_RF);
    assign bus_valid = in_wb || in_rf;
    assign beat_done = bus_valid && bus_ready;

`ifdef BUS_TIMEOUT_EN
    logic [7:0] to_cnt_q, to_cnt_d;

    // 255th consecutive unanswered cycle aborts the burst
    assign timeout = bus_valid && !bus_ready && (to_cnt_q == 8'd254);

    always_comb begin
        to_cnt_d = 8'd0;
        if (bus_valid && !bus_ready && !timeout) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= 8'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rf_base_d = rf_base_q;
        wb_base_d = wb_base_q;
        flush_d   = flush_q;
        case (state_q)
            S_IDLE: begin
                if (core_req && line_miss) begin
                    rf_base_d = access_addr & ~LINE_MASK;
                    wb_base_d = victim_addr;
                    flush_d   = 1'b0;
                    state_d   = replace_dirty ? S_WB : S_RF;
                end else if (flush_req) begin
                    flush_d   = 1'b1;
                    wb_base_d = victim_addr;
                    state_d   = any_dirty ? S_FWB : S_DONE;
                end else if (inval_req) begin
                    flush_d = 1'b0;
                    state_d = S_INV;
                end
            end
            S_WB, S_FWB, S_RF: begin
                if (timeout) begin
                    beat_d  = '0;
                    state_d = S_IDLE;
                end else if (beat_done) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = in_rf ? S_FILL : S_WBOK;
                    end
                end
            end
            S_WBOK: state_d = flush_q ? S_FCHK : S_RF;
            S_FILL: state_d = S_IDLE;
            S_FCHK: begin
                // Dirty encoder has already moved to the next dirty entry
                if (any_dirty) begin
                    wb_base_d = victim_addr;
                    state_d   = S_FWB;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_INV:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            rf_base_q <= '0;
            wb_base_q <= '0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            rf_base_q <= rf_base_d;
            wb_base_q <= wb_base_d;
            flush_q   <= flush_d;
        end
    end

    assign bus_we       = in_wb;
    assign bus_addr     = bus_valid ? ((in_rf ? rf_base_q : wb_base_q) + ADDR_W'({beat_q, 2'b00}))
                                    : '0;
    assign bus_wdata    = mem_rdata;
    assign mem_off      = beat_q;
    assign mem_we       = in_rf && bus_ready;
    assign mem_wdata    = bus_rdata;
    assign force_sync   = (state_q == S_FWB) || (state_q == S_FCHK) ||
                          ((state_q == S_WBOK) && flush_q);
    assign line_refill  = (state_q == S_FILL);
    assign writeback_ok = (state_q == S_WBOK);
    assign valid_clear  = (state_q == S_INV);
    assign maint_done   = (state_q == S_DONE);
    // Gated by rst_n so the stall also drops while reset is held
    assign core_stall   = rst_n && ((state_q != S_IDLE) || (core_req && line_miss));
    assign bus_err      = timeout;
    assign dbg_state_o  = state_q;

endmodule
